mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit for the RV32M extension.
- Sits in the EX stage beside the single-cycle ALU and consumes the same 4-bit ALU operation codes (`ALU_MUL..`ALU_REMU from defines.v) that the ALU control decoder produces.
- Performs 32-iteration shift-add multiply and restoring divide on operand magnitudes, then applies a sign fix-up.
- Uses a start/busy/done handshake so the hazard unit can stall the pipeline while it runs.

---
 rtl/mdu_iterative.sv | 175 +++++++++++++++++
 tb/tb_mdu_iterative.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, followed by a sign fix-up cycle.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // ALU operation codes shared with the ALU control decoder
  localparam logic [3:0] ALU_MUL    = 4'd8;
  localparam logic [3:0] ALU_MULH   = 4'd9;
  localparam logic [3:0] ALU_MULHSU = 4'd10;
  localparam logic [3:0] ALU_MULHU  = 4'd11;
  localparam logic [3:0] ALU_DIV    = 4'd12;
  localparam logic [3:0] ALU_DIVU   = 4'd13;
  localparam logic [3:0] ALU_REM    = 4'd14;
  localparam logic [3:0] ALU_REMU   = 4'd15;

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              is_mul, is_div, is_rem_op, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    a_signed  = (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
                (op == ALU_DIV) || (op == ALU_REM);
    b_signed  = (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    sa        = a_signed & a[XLEN-1];
    sb        = b_signed & b[XLEN-1];
    a_mag     = sa ? -a : a;
    b_mag     = sb ? -b : b;
    is_mul    = (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    is_div    = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    is_rem_op = (op == ALU_REM) || (op == ALU_REMU);
    div_zero  = (b == '0);
    div_ovf   = ((op == ALU_DIV) || (op == ALU_REM)) && (a == MIN_NEG) && (b == '1);
  end

  // One iteration step of each algorithm; the divide trial carries the bit shifted out of rem
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign prod_neg  = -acc_q;

  always_comb begin
    fix_val = acc_q[XLEN-1:0];
    case (op_q)
      ALU_MUL:                         fix_val = neg_q ? prod_neg[XLEN-1:0] : acc_q[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_val = neg_q ? prod_neg[2*XLEN-1:XLEN]
                                                       : acc_q[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:               fix_val = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                         fix_val = neg_q ? -acc_q[2*XLEN-1:XLEN]
                                                       : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    res_d    = res_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d   = op;
            acc_d  = {{XLEN{1'b0}}, a_mag};
            opnd_d = b_mag;
            cnt_d  = '0;
            neg_d  = is_rem_op ? sa : (sa ^ sb);
            if (is_mul) begin
              state_d = S_MUL;
            end else if (is_div && div_zero) begin
              res_d   = is_rem_op ? a : '1;
              state_d = S_DONE;
            end else if (is_div && div_ovf) begin
              res_d   = is_rem_op ? '0 : MIN_NEG;
              state_d = S_DONE;
            end else if (is_div) begin
              state_d = S_DIV;
            end else begin
              res_d   = '0;
              state_d = S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_d   = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CNT_LAST) ? S_FIX : S_MUL;
        end
        S_DIV: begin
          acc_d   = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CNT_LAST) ? S_FIX : S_DIV;
        end
        S_FIX: begin
          res_d   = fix_val;
          cnt_d   = '0;
          state_d = S_DONE;
        end
        S_DONE: begin
          result_d = res_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // The done pulse is registered out of DONE, so busy has already dropped when it appears
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: expected results and latencies are queued
// at issue and compared when the done pulse appears.
module tb_mdu_iterative;

  localparam logic [3:0] OP_MUL    = 4'd8;
  localparam logic [3:0] OP_MULH   = 4'd9;
  localparam logic [3:0] OP_MULHSU = 4'd10;
  localparam logic [3:0] OP_MULHU  = 4'd11;
  localparam logic [3:0] OP_DIV    = 4'd12;
  localparam logic [3:0] OP_DIVU   = 4'd13;
  localparam logic [3:0] OP_REM    = 4'd14;
  localparam logic [3:0] OP_REMU   = 4'd15;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    int          edges;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_last = '0;

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  // Drive a start for one edge (edge k); returns at #1 after edge k
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
  endtask

  // Counts edges from k (e0 already elapsed) until done is seen; e=-1 on timeout
  task automatic wait_done(input int e0, output logic [31:0] r, output int e, output logic bz);
    e = e0; r = '0; bz = 1'b1;
    while (!done && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    if (done) begin
      r = result; bz = busy;
    end else begin
      e = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("txn reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_mul();
    logic [3:0]  ops [5];
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [31:0] ev [5];
    logic [31:0] r;
    int          e;
    logic        bz;
    exp_t        x;
    ops = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULH};
    av  = '{32'd7, 32'd7, 32'd7, 32'hFFFFFFFF, 32'h80000000};
    bv  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    ev  = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFFF, 32'h40000000};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], av[i], bv[i]);
      sb.push_back('{res: ev[i], edges: 35});
      wait_done(1, r, e, bz);
      x = sb.pop_front();
      exp_last = x.res;
      $display("txn mul[%0d]: op=%0d a=%h b=%h result=%h edges=%0d", i, ops[i], av[i], bv[i], r, e);
      n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, r, x.res); end
      n_checks++; if (e !== x.edges) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, e, x.edges); end
      n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_done[%0d]: got %b expected 0", i, bz); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse[%0d]: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops [8];
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] ev [8];
    int          lv [8];
    logic [31:0] r;
    int          e;
    logic        bz;
    exp_t        x;
    ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM};
    av  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    bv  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ev  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    lv  = '{35, 35, 35, 35, 2, 2, 2, 2};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], av[i], bv[i]);
      sb.push_back('{res: ev[i], edges: lv[i]});
      wait_done(1, r, e, bz);
      x = sb.pop_front();
      exp_last = x.res;
      $display("txn div[%0d]: op=%0d a=%h b=%h result=%h edges=%0d", i, ops[i], av[i], bv[i], r, e);
      n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, x.res); end
      n_checks++; if (e !== x.edges) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, e, x.edges); end
      n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL div_busy_at_done[%0d]: got %b expected 0", i, bz); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int          e;
    logic        bz;
    int          dones;
    exp_t        x;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    $display("txn flush: busy=%b result=%h done_pulses=%0d", busy, result, dones);
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones); end
    n_checks++; if (result !== exp_last) begin n_fail++; $display("FAIL flush_result_held: got %h expected %h", result, exp_last); end

    // New MUL right after, with a stray start pulse while it is busy
    issue(OP_MUL, 32'd3, 32'd4);
    sb.push_back('{res: 32'd12, edges: 35});
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = OP_DIVU; a = 32'd99; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, r, e, bz);
    x = sb.pop_front();
    exp_last = x.res;
    $display("txn flush_mul: op=%0d a=3 b=4 result=%h edges=%0d", OP_MUL, r, e);
    n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL ignored_start_result: got %h expected %h", r, x.res); end
    n_checks++; if (e !== x.edges) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected %0d", e, x.edges); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL ignored_start_not_queued: got %0d pulses expected 0", dones); end
    n_checks++; if (result !== exp_last) begin n_fail++; $display("FAIL ignored_start_hold: got %h expected %h", result, exp_last); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] ev [3];
    logic [31:0] r;
    int          e;
    logic        bz;
    exp_t        x;
    ops = '{OP_DIVU, OP_MULHU, OP_REMU};
    av  = '{32'd1000, 32'hFFFF0000, 32'd1000};
    bv  = '{32'd10, 32'h00010000, 32'd7};
    ev  = '{32'd100, 32'h0000FFFF, 32'd6};
    // Each start lands in the cycle the previous done pulse is visible
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], av[i], bv[i]);
      sb.push_back('{res: ev[i], edges: 35});
      wait_done(1, r, e, bz);
      x = sb.pop_front();
      exp_last = x.res;
      $display("txn b2b[%0d]: op=%0d a=%h b=%h result=%h edges=%0d", i, ops[i], av[i], bv[i], r, e);
      n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, r, x.res); end
      n_checks++; if (e !== x.edges) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, e, x.edges); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsupported();
    logic [31:0] r;
    int          e;
    logic        bz;
    exp_t        x;
    issue(4'd3, 32'h12345678, 32'h9ABCDEF0);
    sb.push_back('{res: 32'd0, edges: 2});
    wait_done(1, r, e, bz);
    x = sb.pop_front();
    exp_last = x.res;
    $display("txn unsupported: op=3 result=%h edges=%0d", r, e);
    n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL unsupported_result: got %h expected %h", r, x.res); end
    n_checks++; if (e !== x.edges) begin n_fail++; $display("FAIL unsupported_latency: got %0d expected %0d", e, x.edges); end
    n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL unsupported_busy_at_done: got %b expected 0", bz); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int          e;
    logic        bz;
    int          dones;
    exp_t        x;
    issue(OP_MUL, 32'd5, 32'd6);
    sb.push_back('{res: 32'd30, edges: 35});
    wait_done(1, r, e, bz);
    x = sb.pop_front();
    $display("txn pre_reset_mul: a=5 b=6 result=%h edges=%0d", r, e);
    n_checks++; if (r !== x.res) begin n_fail++; $display("FAIL pre_reset_result: got %h expected %h", r, x.res); end

    issue(OP_MUL, 32'd123, 32'd456);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected 00000000", result); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    $display("txn midreset: busy=%b result=%h done_pulses=%0d", busy, result, dones);
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_unsupported();
    test_reset_mid();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
